// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI receive path:
//   - MIDI status constants (note-off/on nibbles, system and real-time ranges)
//   - bit offsets of the 16-bit note word {on, velocity[6:0], 1'b0, note[6:0]}
//   - UART and parser state enums
//   - make_note_word(): packs the note word from its fields
// -----------------------------------------------------------------------------
package midi_pkg;

   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;
   localparam logic [7:0] MIDI_SYS_MIN  = 8'hF0;

   // Note word layout
   localparam int NOTE_ON_BIT  = 15;
   localparam int NOTE_VEL_LSB = 8;
   localparam int NOTE_KEY_LSB = 0;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_t;

   typedef enum logic [1:0] {
      WAIT_STATUS,
      WAIT_D1,
      WAIT_D2
   } parser_state_t;

   function automatic logic [15:0] make_note_word(input logic       on,
                                                  input logic [6:0] velocity,
                                                  input logic [6:0] note);
      logic [15:0] w;
      w                      = '0;
      w[NOTE_ON_BIT]         = on;
      w[NOTE_VEL_LSB +: 7]   = velocity;
      w[NOTE_KEY_LSB +: 7]   = note;
      return w;
   endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// -----------------------------------------------------------------------------
// midi_rx_parser_if
// Note handshake between the MIDI parser (master) and the MIDI memory
// manager (slave).
//   midi_note_out       16-bit note word of the last accepted message
//   note_for_mem        sticky "new note available" flag
//   reset_note_for_mem  level acknowledge from the consumer
// -----------------------------------------------------------------------------
interface midi_rx_parser_if;

   logic [15:0] midi_note_out;
   logic        note_for_mem;
   logic        reset_note_for_mem;

   modport master (
      output midi_note_out,
      output note_for_mem,
      input  reset_note_for_mem
   );

   modport slave (
      input  midi_note_out,
      input  note_for_mem,
      output reset_note_for_mem
   );

endinterface

// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
// 2-flop synchroniser plus 8N1 UART receiver for the MIDI line.
//   clk         system clock
//   reset       asynchronous, active-low reset
//   midi_in     raw MIDI line, idle high, asynchronous to clk
//   rx          synchronised line level
//   data_byte   last received byte (valid while byte_valid is high)
//   byte_valid  one-cycle pulse, byte received with a high stop bit
//   frame_err   one-cycle pulse, byte received with a low stop bit
// The stop bit is sampled at its middle and the FSM returns to idle at once,
// so a start bit immediately following the stop bit is still caught.
// -----------------------------------------------------------------------------
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1600
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       midi_in,
   output logic       rx,
   output logic [7:0] data_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             sync_ff1;
   logic             rx_d;
   uart_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             byte_valid_nxt;
   logic             frame_err_nxt;

   // The shift register only moves in DATA, so it is stable when byte_valid fires.
   assign data_byte = shreg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_ff1   <= 1'b1;
         rx         <= 1'b1;
         rx_d       <= 1'b1;
         state      <= UART_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop here samples the
         // pre-edge value of the others (sync_ff1 -> rx -> rx_d is a chain).
         sync_ff1   <= midi_in;
         rx         <= sync_ff1;
         rx_d       <= rx;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bit_idx    <= bit_idx_nxt;
         shreg      <= shreg_nxt;
         byte_valid <= byte_valid_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before the case, so
      // no path leaves one unassigned and no latch is inferred.
      state_nxt      = state;
      cnt_nxt        = cnt + 1'b1;
      bit_idx_nxt    = bit_idx;
      shreg_nxt      = shreg;
      byte_valid_nxt = 1'b0;
      frame_err_nxt  = 1'b0;

      case (state)
         UART_IDLE: begin
            cnt_nxt = '0;
            if (rx_d && !rx) begin
               state_nxt = UART_START;
            end
         end

         UART_START: begin
            // Mid start bit: a line that is high again was only a glitch.
            if (cnt == CNT_HALF) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = rx ? UART_IDLE : UART_DATA;
            end
         end

         UART_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt     = '0;
               shreg_nxt   = {rx, shreg[7:1]};   // LSB first
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = UART_STOP;
               end
            end
         end

         UART_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt        = '0;
               byte_valid_nxt = rx;
               frame_err_nxt  = !rx;
               state_nxt      = UART_IDLE;
            end
         end

         default: begin
            state_nxt = UART_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/midi_rx_parser.sv
// -----------------------------------------------------------------------------
// midi_rx_parser
// MIDI front end: receives the raw MIDI line, deserialises 8N1 bytes and
// turns Note-On / Note-Off messages (with running status) into 16-bit note
// words {on, velocity[6:0], 1'b0, note[6:0]} held under a sticky flag.
//   clk        system clock
//   reset      asynchronous, active-low reset
//   midi_in    raw MIDI line, idle high
//   rx         synchronised line level (activity LED)
//   overrun    sticky: a note completed while note_for_mem was still set
//   frame_err  one-cycle pulse on a byte with a low stop bit
//   note_if    note word / sticky flag / acknowledge to the memory manager
// -----------------------------------------------------------------------------
module midi_rx_parser
   import midi_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 31_250
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             midi_in,
   output logic             rx,
   output logic             overrun,
   output logic             frame_err,
   midi_rx_parser_if.master note_if
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   logic [7:0]    rx_byte;
   logic          byte_valid;

   parser_state_t p_state, p_state_nxt;
   logic          rs_valid, rs_valid_nxt;   // a running status is held
   logic          rs_on, rs_on_nxt;         // held status is 0x9n
   logic [6:0]    note_key, note_key_nxt;
   logic [15:0]   note_word, note_word_nxt;
   logic          note_flag, note_flag_nxt;
   logic          overrun_nxt;
   logic          complete;

   midi_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk        (clk),
      .reset      (reset),
      .midi_in    (midi_in),
      .rx         (rx),
      .data_byte  (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign note_if.midi_note_out = note_word;
   assign note_if.note_for_mem  = note_flag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_state   <= WAIT_STATUS;
         rs_valid  <= 1'b0;
         rs_on     <= 1'b0;
         note_key  <= '0;
         note_word <= '0;
         note_flag <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         p_state   <= p_state_nxt;
         rs_valid  <= rs_valid_nxt;
         rs_on     <= rs_on_nxt;
         note_key  <= note_key_nxt;
         note_word <= note_word_nxt;
         note_flag <= note_flag_nxt;
         overrun   <= overrun_nxt;
      end
   end

   always_comb begin
      p_state_nxt  = p_state;
      rs_valid_nxt = rs_valid;
      rs_on_nxt    = rs_on;
      note_key_nxt = note_key;
      complete     = 1'b0;

      // Real-time bytes (0xF8-0xFF) fall through untouched in every state.
      if (byte_valid && (rx_byte < MIDI_RT_MIN)) begin
         if (rx_byte >= MIDI_SYS_MIN) begin
            rs_valid_nxt = 1'b0;
            p_state_nxt  = WAIT_STATUS;
         end else if (rx_byte[7]) begin
            // A status byte aborts any partial message.
            if ((rx_byte[7:4] == MIDI_NOTE_ON) || (rx_byte[7:4] == MIDI_NOTE_OFF)) begin
               rs_valid_nxt = 1'b1;
               rs_on_nxt    = (rx_byte[7:4] == MIDI_NOTE_ON);
               p_state_nxt  = WAIT_D1;
            end else begin
               rs_valid_nxt = 1'b0;
               p_state_nxt  = WAIT_STATUS;
            end
         end else begin
            case (p_state)
               WAIT_STATUS: begin
                  if (rs_valid) begin
                     note_key_nxt = rx_byte[6:0];
                     p_state_nxt  = WAIT_D2;
                  end
               end
               WAIT_D1: begin
                  note_key_nxt = rx_byte[6:0];
                  p_state_nxt  = WAIT_D2;
               end
               WAIT_D2: begin
                  complete    = 1'b1;
                  p_state_nxt = WAIT_D1;
               end
               default: begin
                  p_state_nxt = WAIT_STATUS;
               end
            endcase
         end
      end

      // Handshake: a completion wins over a same-cycle acknowledge.
      note_word_nxt = note_word;
      note_flag_nxt = note_flag;
      if (complete) begin
         note_word_nxt = make_note_word(rs_on && (rx_byte[6:0] != 7'd0),
                                        rx_byte[6:0], note_key);
         note_flag_nxt = 1'b1;
      end else if (note_if.reset_note_for_mem) begin
         note_flag_nxt = 1'b0;
      end

      overrun_nxt = overrun | (complete & note_flag);
   end

endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Serial MIDI front end for the game: receives the raw MIDI line from the keyboard, deserialises 31 250-baud 8N1 bytes, and parses Note-On/Note-Off messages, including running status. It produces one 16-bit note word per completed message and holds it under a sticky `note_for_mem` flag until the MIDI memory manager acknowledges it. It sits directly upstream of the MIDI memory manager and VGA stage, in the `normalClock` domain.

## Interface
- `CLK_HZ`, 50_000_000: frequency of `clk` in Hz.
- `BAUD`, 31_250: MIDI line rate.
- `clk`  in  1  system clock (`normalClock`).
- `reset`  in  1  asynchronous, active-low reset.
- `midi_in`  in  1  raw MIDI line; idle high; asynchronous to `clk`.
- `rx`  out  1  synchronised line level, for the activity LED.
- `midi_note_out`  out  16  `{on, velocity[6:0], 1'b0, note[6:0]}` of the last accepted message.
- `note_for_mem`  out  1  sticky "new note available" flag.
- `reset_note_for_mem`  in  1  acknowledge from the consumer; clears `note_for_mem`.
- `overrun`  out  1  sticky; a new note arrived while `note_for_mem` was still set. Cleared only by reset.
- `frame_err`  out  1  one-cycle pulse when a received byte has a low stop bit.

## Operation
- **Reset values.**
  - `rx` = 1, and the synchroniser flops = 1.
  - `midi_note_out` = 0, `note_for_mem` = 0, `overrun` = 0, `frame_err` = 0.
  - Running status cleared; both FSMs idle.
- **Synchroniser.** `midi_in` passes through a 2-flop synchroniser; the second flop drives `rx`.
- **UART FSM (states IDLE, START, DATA, STOP).**
  - `CLKS_PER_BIT` = `CLK_HZ/BAUD`, integer division; this is 1600 at the default clock. Counter width is `$clog2(CLKS_PER_BIT)`.
  - IDLE → START on a falling edge of the synchronised line.
  - START: at `CLKS_PER_BIT/2`, sample the line. If it is low, go to DATA. If it is high (glitch), go back to IDLE with no output.
  - DATA: sample 8 bits LSB-first, one every `CLKS_PER_BIT` cycles.
  - STOP: sample the stop bit.
    - Stop bit high: raise `byte_valid` for one cycle.
    - Stop bit low: pulse `frame_err` and discard the byte.
    - In both cases go to IDLE immediately. There is no wait for the end of the stop bit, so back-to-back bytes are caught.
- **Parser FSM (states WAIT_STATUS, WAIT_D1, WAIT_D2)**, advanced by `byte_valid`.
  - Bytes 0xF8–0xFF (real-time): ignored in every state. State and running status are unchanged.
  - Bytes 0xF0–0xF7: clear running status and go to WAIT_STATUS.
  - 0x8n or 0x9n, any channel n (omni): latch as running status and go to WAIT_D1. This applies from any state, so a status byte arriving mid-message aborts the partial message.
  - Other status bytes (0xA0–0xEF): clear running status and go to WAIT_STATUS; their data bytes are ignored.
  - Data byte (bit 7 = 0):
    - In WAIT_STATUS: handled as a D1 if a running status is held, otherwise dropped.
    - In WAIT_D1: latch the note and go to WAIT_D2.
    - In WAIT_D2: completes the message and returns to WAIT_D1, keeping the running status.
- **Message completion.**
  - `on` = 1 if the status is 0x9n and velocity ≠ 0; `on` = 0 for 0x8n or for velocity 0.
  - `midi_note_out` is updated.
  - `note_for_mem` is set.
  - If `note_for_mem` was already 1, `overrun` is also set. The new word overwrites the old one.
- **Handshake.** `reset_note_for_mem` is level-sampled. While it is high, `note_for_mem` is cleared, unless a completion occurs in the same cycle, in which case set wins. `midi_note_out` holds its value after the clear.

## Timing
- Line to `rx`: 2 cycles.
- Falling edge of the start bit to `byte_valid`: 9.5 × `CLKS_PER_BIT` + 3 cycles, ±1.
- `byte_valid` of D2 to `note_for_mem` = 1 and `midi_note_out` valid: 1 cycle; both registered, same edge.
- `reset_note_for_mem` high to `note_for_mem` = 0: 1 cycle.
- `frame_err`: registered, high for exactly 1 cycle, on the cycle after the stop-bit sample.
- Asynchronous reset mid-byte or mid-message abandons all partial state. The first valid byte after reset release starts cleanly.

## Structure
- A shared package `midi_pkg` holds:
  - the status constants `MIDI_NOTE_OFF` = 4'h8, `MIDI_NOTE_ON` = 4'h9, `MIDI_RT_MIN` = 8'hF8, `MIDI_SYS_MIN` = 8'hF0;
  - the note-word field offsets;
  - the UART and parser state enums.
- One sub-module, `midi_uart_rx` (synchroniser plus UART FSM, outputs `byte`/`byte_valid`/`frame_err`). The parser and handshake live in the top module.

## Test plan
- Bytes 0x90, 0x3C, 0x64 → `midi_note_out` = 0xE43C, `note_for_mem` = 1. Then pulse `reset_note_for_mem` → `note_for_mem` = 0 one cycle later, and the word holds 0xE43C.
- Running status: 0x93, 0x40, 0x7F, then 0x41, 0x00 (acknowledging between notes) → words 0xFF40 then 0x0041, `overrun` = 0.
- 0x90, 0x3C, 0xF8, 0x50 (real-time byte mid-message) → 0xD03C. Also 0x90, 0x3C, 0x91, 0x45, 0x20 → a single word, 0xA045.
- Two complete notes with no acknowledge → `overrun` = 1, and the word equals the second note.
- Byte with stop bit = 0 → one `frame_err` pulse, parser state unchanged. A 0.3-bit low glitch on an idle line → no `byte_valid`.
- `reset` asserted after 4 data bits of the D2 byte → all outputs at reset values. Then 0x80, 0x3C, 0x40 → 0x403C.
